// File: rtl/fp_adder_arbiter_if.sv
// Bus bundle for fp_adder_arbiter: two requester operand/result channels plus the
// shared adder's a/b/z stb-ack ports. "master" is the arbiter side, "slave" the environment.
interface fp_adder_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_stb;
   logic             req0_ack;
   logic [WIDTH-1:0] res0_z;
   logic             res0_z_stb;
   logic             res0_z_ack;

   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_stb;
   logic             req1_ack;
   logic [WIDTH-1:0] res1_z;
   logic             res1_z_stb;
   logic             res1_z_ack;

   logic [WIDTH-1:0] add_a;
   logic             add_a_stb;
   logic             add_a_ack;
   logic [WIDTH-1:0] add_b;
   logic             add_b_stb;
   logic             add_b_ack;
   logic [WIDTH-1:0] add_z;
   logic             add_z_stb;
   logic             add_z_ack;

   modport master (
      input  req0_a, req0_b, req0_stb, res0_z_ack,
      input  req1_a, req1_b, req1_stb, res1_z_ack,
      input  add_a_ack, add_b_ack, add_z, add_z_stb,
      output req0_ack, res0_z, res0_z_stb,
      output req1_ack, res1_z, res1_z_stb,
      output add_a, add_a_stb, add_b, add_b_stb, add_z_ack
   );

   modport slave (
      output req0_a, req0_b, req0_stb, res0_z_ack,
      output req1_a, req1_b, req1_stb, res1_z_ack,
      output add_a_ack, add_b_ack, add_z, add_z_stb,
      input  req0_ack, res0_z, res0_z_stb,
      input  req1_ack, res1_z, res1_z_stb,
      input  add_a, add_a_stb, add_b, add_b_stb, add_z_ack
   );
endinterface

// File: rtl/fp_adder_arbiter.sv
// Two-requester arbiter sharing one stb/ack floating-point adder, one operation in flight.
// Define FP_ADDER_ARBITER_STATS_EN to add per-requester 16-bit grant counters.
module fp_adder_arbiter #(
   parameter int WIDTH       = 32,
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
`ifdef FP_ADDER_ARBITER_STATS_EN
   output logic [15:0] grant_cnt0,
   output logic [15:0] grant_cnt1,
`endif
   fp_adder_arbiter_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      SEND_A,
      SEND_B,
      WAIT_Z,
      RETURN
   } state_t;

   state_t           state;
   logic             grant;
   logic             last_grant;
   logic             pick;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   // On a tie, round-robin favours whoever was not served last.
   always_comb begin
      pick = 1'b0;
      if (bus.req0_stb && bus.req1_stb) begin
         pick = ROUND_ROBIN ? ~last_grant : 1'b0;
      end else if (bus.req1_stb) begin
         pick = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         grant          <= 1'b0;
         last_grant     <= 1'b1;
         op_a           <= '0;
         op_b           <= '0;
         bus.req0_ack   <= 1'b0;
         bus.req1_ack   <= 1'b0;
         bus.res0_z     <= '0;
         bus.res0_z_stb <= 1'b0;
         bus.res1_z     <= '0;
         bus.res1_z_stb <= 1'b0;
         bus.add_a      <= '0;
         bus.add_a_stb  <= 1'b0;
         bus.add_b      <= '0;
         bus.add_b_stb  <= 1'b0;
         bus.add_z_ack  <= 1'b0;
`ifdef FP_ADDER_ARBITER_STATS_EN
         grant_cnt0     <= '0;
         grant_cnt1     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0_stb || bus.req1_stb) begin
                  if (pick) begin
                     bus.req1_ack <= 1'b1;
                     op_a         <= bus.req1_a;
                     op_b         <= bus.req1_b;
`ifdef FP_ADDER_ARBITER_STATS_EN
                     grant_cnt1   <= grant_cnt1 + 16'd1;
`endif
                  end else begin
                     bus.req0_ack <= 1'b1;
                     op_a         <= bus.req0_a;
                     op_b         <= bus.req0_b;
`ifdef FP_ADDER_ARBITER_STATS_EN
                     grant_cnt0   <= grant_cnt0 + 16'd1;
`endif
                  end
                  grant      <= pick;
                  last_grant <= pick;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               bus.req0_ack  <= 1'b0;
               bus.req1_ack  <= 1'b0;
               bus.add_a     <= op_a;
               bus.add_a_stb <= 1'b1;
               state         <= SEND_A;
            end
            SEND_A: begin
               if (bus.add_a_stb && bus.add_a_ack) begin
                  bus.add_a_stb <= 1'b0;
                  bus.add_b     <= op_b;
                  bus.add_b_stb <= 1'b1;
                  state         <= SEND_B;
               end
            end
            SEND_B: begin
               if (bus.add_b_stb && bus.add_b_ack) begin
                  bus.add_b_stb <= 1'b0;
                  bus.add_z_ack <= 1'b1;
                  state         <= WAIT_Z;
               end
            end
            // The result goes to the captured grant, whatever the req stb lines do now.
            WAIT_Z: begin
               if (bus.add_z_stb && bus.add_z_ack) begin
                  bus.add_z_ack <= 1'b0;
                  if (grant) begin
                     bus.res1_z     <= bus.add_z;
                     bus.res1_z_stb <= 1'b1;
                  end else begin
                     bus.res0_z     <= bus.add_z;
                     bus.res0_z_stb <= 1'b1;
                  end
                  state <= RETURN;
               end
            end
            RETURN: begin
               if (grant) begin
                  if (bus.res1_z_stb && bus.res1_z_ack) begin
                     bus.res1_z_stb <= 1'b0;
                     state          <= IDLE;
                  end
               end else begin
                  if (bus.res0_z_stb && bus.res0_z_ack) begin
                     bus.res0_z_stb <= 1'b0;
                     state          <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Self-checking bench for fp_adder_arbiter: behavioural stalling adder, result scoreboard,
// and a second fixed-priority instance for the priority check.
module tb_fp_adder_arbiter;

   localparam int WIDTH = 32;
   localparam logic [31:0] A0 = 32'h3F800000;
   localparam logic [31:0] B0 = 32'h40000000;
   localparam logic [31:0] Z0 = 32'h40400000;
   localparam logic [31:0] A1 = 32'h40A00000;
   localparam logic [31:0] B1 = 32'h3F800000;
   localparam logic [31:0] Z1 = 32'h40C00000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_adder_arbiter_if #(.WIDTH(WIDTH)) bus ();
   fp_adder_arbiter_if #(.WIDTH(WIDTH)) bus_fp ();

`ifdef FP_ADDER_ARBITER_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1, fp_cnt0, fp_cnt1;
`endif

   fp_adder_arbiter #(.WIDTH(WIDTH), .ROUND_ROBIN(1'b1)) dut (
      .clk(clk),
      .rst(rst),
`ifdef FP_ADDER_ARBITER_STATS_EN
      .grant_cnt0(grant_cnt0),
      .grant_cnt1(grant_cnt1),
`endif
      .bus(bus)
   );

   fp_adder_arbiter #(.WIDTH(WIDTH), .ROUND_ROBIN(1'b0)) dut_fp (
      .clk(clk),
      .rst(rst),
`ifdef FP_ADDER_ARBITER_STATS_EN
      .grant_cnt0(fp_cnt0),
      .grant_cnt1(fp_cnt1),
`endif
      .bus(bus_fp)
   );

   // Fixed-priority instance: both requesters always asking, adder and sinks always ready.
   assign bus_fp.req0_a     = A0;
   assign bus_fp.req0_b     = B0;
   assign bus_fp.req0_stb   = 1'b1;
   assign bus_fp.res0_z_ack = 1'b1;
   assign bus_fp.req1_a     = A1;
   assign bus_fp.req1_b     = B1;
   assign bus_fp.req1_stb   = 1'b1;
   assign bus_fp.res1_z_ack = 1'b1;
   assign bus_fp.add_a_ack  = 1'b1;
   assign bus_fp.add_b_ack  = 1'b1;
   assign bus_fp.add_z      = Z0;
   assign bus_fp.add_z_stb  = 1'b1;

   int checks = 0;
   int errors = 0;
   int a_delay = 0;
   int z_delay = 0;
   int ack0_cnt = 0, ack1_cnt = 0, a_xfers = 0, b_xfers = 0;
   int fp_ack0 = 0, fp_ack1 = 0, fp_res1 = 0;
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   bit          exp_grant[$];

   function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
      if (a == A0 && b == B0) return Z0;
      if (a == A1 && b == B1) return Z1;
      return 32'hDEADBEEF;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input bit which, input bit stb, input logic [31:0] a, input logic [31:0] b);
      if (which) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_stb = stb;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_stb = stb;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      a_delay = 0;
      z_delay = 0;
      bus.req0_stb = 1'b0;
      bus.req1_stb = 1'b0;
      bus.res0_z_ack = 1'b1;
      bus.res1_z_ack = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      exp0.delete(); exp1.delete(); exp_grant.delete();
      ack0_cnt = 0; ack1_cnt = 0; a_xfers = 0; b_xfers = 0;
      fp_ack0 = 0; fp_ack1 = 0; fp_res1 = 0;
   endtask

   task automatic waitAcks(input int target, input string tag);
      int n = 0;
      while ((ack0_cnt + ack1_cnt) < target && n < 300) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'((ack0_cnt + ack1_cnt) >= target), 32'd1);
   endtask

   task automatic waitDrain(input string tag);
      int n = 0;
      while ((exp0.size() + exp1.size() != 0 || bus.res0_z_stb || bus.res1_z_stb) && n < 500) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(n < 500), 32'd1);
   endtask

   // Behavioural adder with programmable a-ack and result delays; reset by the same rst.
   initial begin
      int m_state = 0;
      int m_cnt = 0;
      logic [31:0] m_a = '0;
      logic [31:0] m_b = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            bus.add_a_ack <= 1'b0;
            bus.add_b_ack <= 1'b0;
            bus.add_z_stb <= 1'b0;
            bus.add_z     <= '0;
            m_state = 0;
            m_cnt = 0;
         end else begin
            case (m_state)
               0: if (bus.add_a_stb && bus.add_a_ack) begin
                     m_a = bus.add_a; bus.add_a_ack <= 1'b0; m_cnt = 0; m_state = 1;
                  end else if (bus.add_a_stb) begin
                     if (m_cnt >= a_delay) bus.add_a_ack <= 1'b1;
                     else m_cnt++;
                  end
               1: if (bus.add_b_stb && bus.add_b_ack) begin
                     m_b = bus.add_b; bus.add_b_ack <= 1'b0; m_cnt = 0; m_state = 2;
                  end else if (bus.add_b_stb) begin
                     bus.add_b_ack <= 1'b1;
                  end
               2: if (m_cnt >= z_delay) begin
                     bus.add_z <= fadd_model(m_a, m_b); bus.add_z_stb <= 1'b1; m_state = 3;
                  end else begin
                     m_cnt++;
                  end
               default: if (bus.add_z_stb && bus.add_z_ack) begin
                     bus.add_z_stb <= 1'b0; m_cnt = 0; m_state = 0;
                  end
            endcase
         end
      end
   end

   // Monitor: grant order, ack pulses, result scoreboard, a-before-b ordering, operand stability.
   initial begin
      logic prev_ack = 1'b0, prev_res0 = 1'b0, prev_res1 = 1'b0;
      logic prev_a_stb = 1'b0, prev_a_ack = 1'b0, prev_b_stb = 1'b0;
      logic [31:0] prev_add_a = '0;
      bit g;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.req0_ack || bus.req1_ack) begin
               checkOutput("dual_req_ack", 32'(bus.req0_ack & bus.req1_ack), 32'd0);
               checkOutput("req_ack_pulse", 32'(prev_ack), 32'd0);
               if (bus.req0_ack) ack0_cnt++;
               if (bus.req1_ack) ack1_cnt++;
               if (exp_grant.size() == 0) begin
                  checkOutput("unexpected_grant", 32'(bus.req1_ack), 32'hFFFFFFFF);
               end else begin
                  g = exp_grant.pop_front();
                  checkOutput("grant_order", 32'(bus.req1_ack), 32'(g));
               end
            end
            if (bus.res0_z_stb && !prev_res0) begin
               checkOutput("dual_res_stb", 32'(bus.res1_z_stb), 32'd0);
               if (exp0.size() == 0) checkOutput("unexpected_res0", bus.res0_z, 32'hFFFFFFFF);
               else checkOutput("res0_value", bus.res0_z, exp0.pop_front());
            end
            if (bus.res1_z_stb && !prev_res1) begin
               checkOutput("dual_res_stb", 32'(bus.res0_z_stb), 32'd0);
               if (exp1.size() == 0) checkOutput("unexpected_res1", bus.res1_z, 32'hFFFFFFFF);
               else checkOutput("res1_value", bus.res1_z, exp1.pop_front());
            end
            if (bus.add_a_stb && bus.add_a_ack) a_xfers++;
            if (bus.add_b_stb && !prev_b_stb) checkOutput("b_after_a", 32'(a_xfers), 32'(b_xfers + 1));
            if (bus.add_b_stb && bus.add_b_ack) b_xfers++;
            if (bus.add_a_stb && prev_a_stb && !prev_a_ack) checkOutput("add_a_stable", bus.add_a, prev_add_a);
            if (bus_fp.req0_ack) fp_ack0++;
            if (bus_fp.req1_ack) fp_ack1++;
            if (bus_fp.res1_z_stb) fp_res1++;
         end
         prev_ack   = bus.req0_ack | bus.req1_ack;
         prev_res0  = bus.res0_z_stb;
         prev_res1  = bus.res1_z_stb;
         prev_a_stb = bus.add_a_stb;
         prev_a_ack = bus.add_a_ack;
         prev_b_stb = bus.add_b_stb;
         prev_add_a = bus.add_a;
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, '0, '0);
      bus.res0_z_ack = 1'b1;
      bus.res1_z_ack = 1'b1;
      repeat (2) tick();
      $display("[TB] reset values");
      checkOutput("rst_stb_ack", 32'({bus.req0_ack, bus.req1_ack, bus.res0_z_stb, bus.res1_z_stb,
                  bus.add_a_stb, bus.add_b_stb, bus.add_z_ack}), 32'd0);
      checkOutput("rst_add_a", bus.add_a, 32'd0);
      checkOutput("rst_add_b", bus.add_b, 32'd0);
      checkOutput("rst_res0_z", bus.res0_z, 32'd0);
      checkOutput("rst_res1_z", bus.res1_z, 32'd0);
`ifdef FP_ADDER_ARBITER_STATS_EN
      checkOutput("rst_cnt", 32'({grant_cnt0, grant_cnt1}), 32'd0);
`endif

      $display("[TB] single request");
      doReset();
      exp_grant.push_back(1'b0);
      exp0.push_back(Z0);
      applyStimulus(1'b0, 1'b1, A0, B0);
      waitAcks(1, "t1_ack_timeout");
      applyStimulus(1'b0, 1'b0, A0, B0);
      waitDrain("t1_drain_timeout");
      checkOutput("t1_req1_idle", 32'(ack1_cnt), 32'd0);
      checkOutput("t1_ack0_once", 32'(ack0_cnt), 32'd1);

      $display("[TB] round-robin, both requesting");
      doReset();
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
      exp0.push_back(Z0); exp0.push_back(Z0);
      exp1.push_back(Z1); exp1.push_back(Z1);
      applyStimulus(1'b0, 1'b1, A0, B0);
      applyStimulus(1'b1, 1'b1, A1, B1);
      waitAcks(4, "t2_ack_timeout");
      applyStimulus(1'b0, 1'b0, A0, B0);
      applyStimulus(1'b1, 1'b0, A1, B1);
      waitDrain("t2_drain_timeout");
      checkOutput("t2_grant_queue", 32'(exp_grant.size()), 32'd0);
`ifdef FP_ADDER_ARBITER_STATS_EN
      checkOutput("t2_cnt0", 32'(grant_cnt0), 32'd2);
      checkOutput("t2_cnt1", 32'(grant_cnt1), 32'd2);
`endif

      $display("[TB] fixed priority instance");
      doReset();
      repeat (60) tick();
      checkOutput("t3_req1_never_acked", 32'(fp_ack1), 32'd0);
      checkOutput("t3_res1_never_valid", 32'(fp_res1), 32'd0);
      checkOutput("t3_req0_served", 32'(fp_ack0 >= 5), 32'd1);
`ifdef FP_ADDER_ARBITER_STATS_EN
      checkOutput("t3_cnt0", 32'(fp_cnt0), 32'(fp_ack0));
      checkOutput("t3_cnt1", 32'(fp_cnt1), 32'd0);
`endif

      $display("[TB] result back-pressure");
      doReset();
      bus.res0_z_ack = 1'b0;
      exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
      exp0.push_back(Z0);
      exp1.push_back(Z1);
      applyStimulus(1'b0, 1'b1, A0, B0);
      waitAcks(1, "t4_ack_timeout");
      applyStimulus(1'b0, 1'b0, A0, B0);
      applyStimulus(1'b1, 1'b1, A1, B1);
      n = 0;
      while (!bus.res0_z_stb && n < 50) begin tick(); n++; end
      checkOutput("t4_res0_timeout", 32'(n < 50), 32'd1);
      for (int i = 0; i < 20; i++) begin
         checkOutput("t4_res0_stb_held", 32'(bus.res0_z_stb), 32'd1);
         checkOutput("t4_res0_z_held", bus.res0_z, Z0);
         checkOutput("t4_req1_blocked", 32'(bus.req1_ack), 32'd0);
         tick();
      end
      bus.res0_z_ack = 1'b1;
      tick();
      checkOutput("t4_res0_released", 32'(bus.res0_z_stb), 32'd0);
      checkOutput("t4_req1_not_yet", 32'(bus.req1_ack), 32'd0);
      tick();
      checkOutput("t4_req1_acked", 32'(bus.req1_ack), 32'd1);
      applyStimulus(1'b1, 1'b0, A1, B1);
      waitDrain("t4_drain_timeout");

      $display("[TB] adder stalls");
      doReset();
      a_delay = 5;
      z_delay = 30;
      exp_grant.push_back(1'b0);
      exp0.push_back(Z0);
      applyStimulus(1'b0, 1'b1, A0, B0);
      waitAcks(1, "t5_ack_timeout");
      applyStimulus(1'b0, 1'b0, A0, B0);
      n = 0;
      while (!bus.add_a_stb && n < 20) begin tick(); n++; end
      checkOutput("t5_add_a_timeout", 32'(n < 20), 32'd1);
      n = 0;
      while (!bus.add_a_ack && n < 20) begin
         checkOutput("t5_b_idle_during_a", 32'(bus.add_b_stb), 32'd0);
         checkOutput("t5_add_a_value", bus.add_a, A0);
         tick();
         n++;
      end
      checkOutput("t5_a_stall_len", 32'(n >= 5 && n < 20), 32'd1);
      waitDrain("t5_drain_timeout");

      $display("[TB] reset during WAIT_Z");
      doReset();
      z_delay = 30;
      exp_grant.push_back(1'b0);
      applyStimulus(1'b0, 1'b1, A0, B0);
      waitAcks(1, "t6_ack_timeout");
      applyStimulus(1'b0, 1'b0, A0, B0);
      n = 0;
      while (!bus.add_z_ack && n < 30) begin tick(); n++; end
      checkOutput("t6_wait_z_timeout", 32'(n < 30), 32'd1);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      checkOutput("t6_rst_stb_ack", 32'({bus.req0_ack, bus.req1_ack, bus.res0_z_stb, bus.res1_z_stb,
                  bus.add_a_stb, bus.add_b_stb, bus.add_z_ack}), 32'd0);
`ifdef FP_ADDER_ARBITER_STATS_EN
      checkOutput("t6_rst_cnt", 32'({grant_cnt0, grant_cnt1}), 32'd0);
`endif
      rst = 1'b0;
      z_delay = 0;
      exp_grant.push_back(1'b1);
      exp1.push_back(Z1);
      applyStimulus(1'b1, 1'b1, A1, B1);
      waitAcks(2, "t6_req1_ack_timeout");
      applyStimulus(1'b1, 1'b0, A1, B1);
      waitDrain("t6_drain_timeout");
      repeat (5) tick();
      checkOutput("t6_no_stale_res0", 32'(bus.res0_z_stb), 32'd0);
`ifdef FP_ADDER_ARBITER_STATS_EN
      checkOutput("t6_cnt0", 32'(grant_cnt0), 32'd0);
      checkOutput("t6_cnt1", 32'(grant_cnt1), 32'd1);
`endif

      checkOutput("end_exp0_empty", 32'(exp0.size()), 32'd0);
      checkOutput("end_exp1_empty", 32'(exp1.size()), 32'd0);
      checkOutput("end_grant_empty", 32'(exp_grant.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
